// File: rtl/clock_div_prog.sv
// Runtime-programmable integer clock divider with a glitch-free divisor
// update buffer and a one-cycle period tick in the fast domain.
module clock_div_prog #(
  parameter int DIV_W = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             div_valid,
  input  logic [DIV_W-1:0] div_value,
  output logic             div_ready,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] cur_div,
  output logic             running,
  output logic             cfg_err
);

  localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MIN_N = DIV_W'(2);

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] n_q, n_d;
  logic [DIV_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             run_q, run_d;
  logic             err_q, err_d;

  logic boundary;
  logic stopped;
  logic apply;
  logic xfer;
  logic illegal;

  assign boundary = run_q && (count_q == n_q - 1'b1);
  assign stopped  = !run_q;
  assign apply    = pend_q && (boundary || stopped);
  assign xfer     = div_valid && !pend_q;
  assign illegal  = (div_value < MIN_N);

  always_comb begin
    count_d    = count_q + 1'b1;
    run_d      = run_q;
    n_d        = n_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    err_d      = err_q;
    if (stopped || boundary) begin
      count_d = '0;
      run_d   = en;
    end
    if (apply) begin
      n_d    = pend_val_q;
      pend_d = 1'b0;
    end
    if (xfer) begin
      pend_d     = 1'b1;
      pend_val_d = illegal ? MIN_N : div_value;
      err_d      = err_q | illegal;
    end
    // Register the level for the count being entered so clk_out tracks count_q.
    clk_out_d = run_d && (count_d >= (n_d >> 1));
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      count_q    <= '0;
      n_q        <= DEF_N;
      pend_q     <= 1'b0;
      pend_val_q <= DEF_N;
      clk_out_q  <= 1'b0;
      run_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      n_q        <= n_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      clk_out_q  <= clk_out_d;
      run_q      <= run_d;
      err_q      <= err_d;
    end
  end

  assign div_ready = !pend_q;
  assign clk_out   = clk_out_q;
  assign tick      = boundary;
  assign cur_div   = n_q;
  assign running   = run_q;
  assign cfg_err   = err_q;

endmodule
